// File: rtl/incrementer_pkg.sv
// Shared definitions for the registered incrementer (default width, data word, all-ones helper).
package incrementer_pkg;

  localparam int INC_WIDTH_DEFAULT = 4;
  localparam int INC_MAX_WIDTH     = 64;

  typedef logic [INC_WIDTH_DEFAULT-1:0] inc_word_t;

  // Returns a word with the low w bits set; callers truncate to their own width.
  function automatic logic [INC_MAX_WIDTH-1:0] all_ones(input int unsigned w);
    logic [INC_MAX_WIDTH-1:0] mask;
    if (w >= INC_MAX_WIDTH) begin
      mask = '1;
    end else begin
      mask = (64'd1 << w) - 64'd1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/incrementer_reg_half_adder.sv
// Single half-adder cell used as one stage of the incrementer ripple chain.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/incrementer_reg.sv
// Registered incrementer: B <= A + 1 through a half-adder ripple chain, with registered carry-out.
// Define INCREMENTER_SATURATE_EN to make the all-ones input saturate instead of wrapping.
module incrementer_reg
  import incrementer_pkg::*;
#(
  parameter int WIDTH = INC_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             cout
);

  localparam logic [WIDTH-1:0] ONES = WIDTH'(all_ones(WIDTH));

  logic [WIDTH:0]   carry_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] b_d, b_q;
  logic             cout_d, cout_q;

  // Carry-in of the first cell is the constant +1.
  assign carry_s[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    half_adder u_ha (
      .a (A[i]),
      .b (carry_s[i]),
      .s (sum_s[i]),
      .c (carry_s[i+1])
    );
  end

  always_comb begin
    b_d    = sum_s;
    cout_d = carry_s[WIDTH];
`ifdef INCREMENTER_SATURATE_EN
    // The final carry is set only for an all-ones input, so it doubles as the saturate select.
    if (carry_s[WIDTH]) begin
      b_d = ONES;
    end else begin
      b_d = sum_s;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      b_q    <= b_d;
      cout_q <= cout_d;
    end
  end

  assign B    = b_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_incrementer_reg.sv
// Directed self-checking bench for incrementer_reg at WIDTH=4 and WIDTH=8.
module tb_incrementer_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a4, b4;
  logic       c4;
  logic [7:0] a8, b8;
  logic       c8;
  int         vectors     = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  incrementer_reg #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .A(a4), .B(b4), .cout(c4));
  incrementer_reg #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .A(a8), .B(b8), .cout(c8));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [3:0] eb, input logic ec);
    vectors++;
    assert (b4 === eb && c4 === ec)
    else begin
      miscompares++;
      $error("FAIL %s: observed B=%h cout=%b expected B=%h cout=%b", tag, b4, c4, eb, ec);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] eb, input logic ec);
    vectors++;
    assert (b8 === eb && c8 === ec)
    else begin
      miscompares++;
      $error("FAIL %s: observed B=%h cout=%b expected B=%h cout=%b", tag, b8, c8, eb, ec);
    end
  endtask

  initial begin
    rst = 1'b1;
    a4  = 4'b0101;
    a8  = 8'h55;

    step(); chk4("reset1", 4'b0000, 1'b0); chk8("reset1_w8", 8'h00, 1'b0);
    step(); chk4("reset2", 4'b0000, 1'b0); chk8("reset2_w8", 8'h00, 1'b0);

    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      a4 = 4'(i);
      step();
      chk4("sweep", 4'(i + 1), 1'b0);
    end

    a4 = 4'b1111;
    step();
`ifdef INCREMENTER_SATURATE_EN
    chk4("all_ones", 4'b1111, 1'b1);
`else
    chk4("all_ones", 4'b0000, 1'b1);
`endif

    a4 = 4'b0001;
    step();
    chk4("mid_pre", 4'b0010, 1'b0);
    #2;
    a4 = 4'b0110;
    #2;
    chk4("mid_hold", 4'b0010, 1'b0);
    step();
    chk4("mid_edge", 4'b0111, 1'b0);

    rst = 1'b1;
    a4  = 4'b1010;
    step();
    chk4("run_reset", 4'b0000, 1'b0);
    rst = 1'b0;
    step();
    chk4("after_reset", 4'b1011, 1'b0);

    a8 = 8'hFF;
    step();
`ifdef INCREMENTER_SATURATE_EN
    chk8("w8_ff", 8'hFF, 1'b1);
`else
    chk8("w8_ff", 8'h00, 1'b1);
`endif
    a8 = 8'h7F;
    step();
    chk8("w8_7f", 8'h80, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
